// File: rtl/odesa_complete_top.sv
// Event-driven time-surface classifier: eight decaying input traces feed four neurons
// with adaptive thresholds; a winner-take-all stage emits one registered one-hot spike.
module odesa_complete_top #(
    parameter int unsigned p_width    = 9,
    parameter int unsigned p_thr_init = 512
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [8:1] i_event,
    output logic [4:1] o_spike_out
);

    localparam logic [p_width-1:0] TMax     = '1;
    localparam logic [p_width-1:0] TraceOne = 1;
    localparam logic [p_width:0]   ThrOne   = 1;
    localparam logic [p_width:0]   ThrInit  = p_thr_init[p_width:0];

    logic [p_width-1:0] trace_q [1:8];
    logic [p_width-1:0] trace_d [1:8];
    logic [p_width:0]   thr_q   [1:4];
    logic [p_width:0]   thr_d   [1:4];
    logic [p_width:0]   pot     [1:4];
    logic               ev_q;
    logic               win_found;
    logic [4:1]         win_oh;
    logic [p_width:0]   best;
    logic [4:1]         spike_d;

    always_comb begin
        for (int n = 1; n <= 8; n++) begin
            if (i_event[n]) begin
                trace_d[n] = TMax;
            end else if (trace_q[n] != '0) begin
                trace_d[n] = trace_q[n] - TraceOne;
            end else begin
                trace_d[n] = trace_q[n];
            end
        end
    end

    // Fixed weight map: neuron k sums inputs 2k-1 and 2k; one extra bit avoids overflow.
    always_comb begin
        for (int k = 1; k <= 4; k++) begin
            pot[k] = {1'b0, trace_q[2*k-1]} + {1'b0, trace_q[2*k]};
        end
    end

    // Strictly-greater comparison while scanning upward keeps ties on the lowest index.
    always_comb begin
        win_found = 1'b0;
        win_oh    = '0;
        best      = '0;
        for (int k = 1; k <= 4; k++) begin
            if (pot[k] >= thr_q[k] && pot[k] != '0 && (!win_found || pot[k] > best)) begin
                win_found = 1'b1;
                win_oh    = '0;
                win_oh[k] = 1'b1;
                best      = pot[k];
            end
        end
    end

    always_comb begin
        spike_d = ev_q ? win_oh : '0;
        for (int k = 1; k <= 4; k++) begin
            thr_d[k] = thr_q[k];
            if (ev_q) begin
                if (win_found) begin
                    // Winner has pot >= thr, so the difference is non-negative and the sum
                    // never exceeds pot.
                    if (win_oh[k]) begin
                        thr_d[k] = thr_q[k] + ((pot[k] - thr_q[k]) >> 2);
                    end
                end else if (thr_q[k] != '0) begin
                    thr_d[k] = thr_q[k] - ThrOne;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 1; n <= 8; n++) begin
                trace_q[n] <= '0;
            end
            for (int k = 1; k <= 4; k++) begin
                thr_q[k] <= ThrInit;
            end
            ev_q        <= 1'b0;
            o_spike_out <= '0;
        end else begin
            for (int n = 1; n <= 8; n++) begin
                trace_q[n] <= trace_d[n];
            end
            for (int k = 1; k <= 4; k++) begin
                thr_q[k] <= thr_d[k];
            end
            ev_q        <= |i_event;
            o_spike_out <= spike_d;
        end
    end

endmodule

// File: tb/tb_odesa_complete_top.sv
// Directed bench for odesa_complete_top: spike timing, winner selection and threshold
// adaptation against hand-computed values.
module tb_odesa_complete_top;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:1] ev;
    logic [4:1] spike;

    int nchecks = 0;
    int nerrors = 0;

    odesa_complete_top #(
        .p_width   (9),
        .p_thr_init(512)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_event    (ev),
        .o_spike_out(spike)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0;
        ev    = '0;
        #100;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns at the negedge just after the sampling edge.
    task automatic pulse(input logic [8:1] v);
        @(negedge clk);
        ev = v;
        @(negedge clk);
        ev = '0;
    endtask

    task automatic test_reset();
        logic [4:1] seen;
        apply_reset();
        nchecks++;
        if (spike !== 4'b0000) begin
            nerrors++;
            $display("FAIL reset_spike: got %b want 0000", spike);
        end
        seen = '0;
        repeat (1000) begin
            @(negedge clk);
            seen = seen | spike;
        end
        nchecks++;
        if (seen !== 4'b0000) begin
            nerrors++;
            $display("FAIL idle_no_spike: got %b want 0000", seen);
        end
        nchecks++;
        if (dut.thr_q[1] !== 10'd512 || dut.thr_q[2] !== 10'd512 ||
            dut.thr_q[3] !== 10'd512 || dut.thr_q[4] !== 10'd512) begin
            nerrors++;
            $display("FAIL idle_thr: got %0d %0d %0d %0d want 512", dut.thr_q[1],
                     dut.thr_q[2], dut.thr_q[3], dut.thr_q[4]);
        end
    endtask

    task automatic test_pair_spike();
        apply_reset();
        pulse(8'b0000_0011);
        nchecks++;
        if (spike !== 4'b0000) begin
            nerrors++;
            $display("FAIL pair_early: got %b want 0000", spike);
        end
        @(negedge clk);
        nchecks++;
        if (spike !== 4'b0001) begin
            nerrors++;
            $display("FAIL pair_spike: got %b want 0001", spike);
        end
        nchecks++;
        if (dut.thr_q[1] !== 10'd639 || dut.thr_q[2] !== 10'd512) begin
            nerrors++;
            $display("FAIL pair_thr: got %0d %0d want 639 512", dut.thr_q[1], dut.thr_q[2]);
        end
        @(negedge clk);
        nchecks++;
        if (spike !== 4'b0000) begin
            nerrors++;
            $display("FAIL pair_one_cycle: got %b want 0000", spike);
        end
    endtask

    task automatic test_single_then_repeat();
        apply_reset();
        pulse(8'b0000_0001);
        @(negedge clk);
        nchecks++;
        if (spike !== 4'b0000) begin
            nerrors++;
            $display("FAIL single_no_spike: got %b want 0000", spike);
        end
        nchecks++;
        if (dut.thr_q[1] !== 10'd511 || dut.thr_q[2] !== 10'd511 ||
            dut.thr_q[3] !== 10'd511 || dut.thr_q[4] !== 10'd511) begin
            nerrors++;
            $display("FAIL single_thr_dec: got %0d %0d %0d %0d want 511", dut.thr_q[1],
                     dut.thr_q[2], dut.thr_q[3], dut.thr_q[4]);
        end
        repeat (8) @(negedge clk);
        pulse(8'b0000_0001);
        @(negedge clk);
        nchecks++;
        if (spike !== 4'b0001) begin
            nerrors++;
            $display("FAIL repeat_spike: got %b want 0001", spike);
        end
        nchecks++;
        if (dut.thr_q[1] !== 10'd511) begin
            nerrors++;
            $display("FAIL repeat_thr: got %0d want 511", dut.thr_q[1]);
        end
    endtask

    task automatic test_decay();
        apply_reset();
        pulse(8'b0000_0001);
        @(negedge clk);
        nchecks++;
        if (spike !== 4'b0000) begin
            nerrors++;
            $display("FAIL decay_first: got %b want 0000", spike);
        end
        repeat (197) @(negedge clk);
        pulse(8'b0000_0010);
        @(negedge clk);
        nchecks++;
        if (spike !== 4'b0001) begin
            nerrors++;
            $display("FAIL decay_spike: got %b want 0001", spike);
        end
        // 511 + ((822 - 511) >> 2)
        nchecks++;
        if (dut.thr_q[1] !== 10'd588) begin
            nerrors++;
            $display("FAIL decay_thr: got %0d want 588", dut.thr_q[1]);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        pulse(8'b0000_1111);
        @(negedge clk);
        nchecks++;
        if (spike !== 4'b0001) begin
            nerrors++;
            $display("FAIL tie_spike: got %b want 0001", spike);
        end
        nchecks++;
        if (dut.thr_q[1] !== 10'd639 || dut.thr_q[2] !== 10'd512) begin
            nerrors++;
            $display("FAIL tie_thr: got %0d %0d want 639 512", dut.thr_q[1], dut.thr_q[2]);
        end
    endtask

    task automatic test_neuron3();
        apply_reset();
        pulse(8'b0011_0000);
        @(negedge clk);
        nchecks++;
        if (spike !== 4'b0100) begin
            nerrors++;
            $display("FAIL n3_spike: got %b want 0100", spike);
        end
        nchecks++;
        if (dut.thr_q[3] !== 10'd639 || dut.thr_q[1] !== 10'd512) begin
            nerrors++;
            $display("FAIL n3_thr: got %0d %0d want 639 512", dut.thr_q[3], dut.thr_q[1]);
        end
    endtask

    // e1,e2 at edge E then e3,e4 at E+1: second evaluation sees P1=1020, P2=1022.
    task automatic test_back_to_back();
        apply_reset();
        @(negedge clk);
        ev = 8'b0000_0011;
        @(negedge clk);
        ev = 8'b0000_1100;
        @(negedge clk);
        ev = '0;
        nchecks++;
        if (spike !== 4'b0001) begin
            nerrors++;
            $display("FAIL b2b_first: got %b want 0001", spike);
        end
        @(negedge clk);
        nchecks++;
        if (spike !== 4'b0010) begin
            nerrors++;
            $display("FAIL b2b_largest: got %b want 0010", spike);
        end
        nchecks++;
        if (dut.thr_q[1] !== 10'd639 || dut.thr_q[2] !== 10'd639) begin
            nerrors++;
            $display("FAIL b2b_thr: got %0d %0d want 639 639", dut.thr_q[1], dut.thr_q[2]);
        end
        @(negedge clk);
        nchecks++;
        if (spike !== 4'b0000) begin
            nerrors++;
            $display("FAIL b2b_idle: got %b want 0000", spike);
        end
    endtask

    task automatic test_midstream_reset();
        logic [8:0] tor;
        apply_reset();
        @(negedge clk);
        ev = 8'hFF;
        repeat (4) @(negedge clk);
        nchecks++;
        if (spike !== 4'b0001) begin
            nerrors++;
            $display("FAIL held_spike: got %b want 0001", spike);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nchecks++;
        if (spike !== 4'b0000) begin
            nerrors++;
            $display("FAIL async_spike: got %b want 0000", spike);
        end
        tor = dut.trace_q[1] | dut.trace_q[2] | dut.trace_q[3] | dut.trace_q[4] |
              dut.trace_q[5] | dut.trace_q[6] | dut.trace_q[7] | dut.trace_q[8];
        nchecks++;
        if (tor !== 9'd0) begin
            nerrors++;
            $display("FAIL async_trace: got %0d want 0", tor);
        end
        nchecks++;
        if (dut.thr_q[1] !== 10'd512 || dut.thr_q[2] !== 10'd512 ||
            dut.thr_q[3] !== 10'd512 || dut.thr_q[4] !== 10'd512) begin
            nerrors++;
            $display("FAIL async_thr: got %0d %0d %0d %0d want 512", dut.thr_q[1],
                     dut.thr_q[2], dut.thr_q[3], dut.thr_q[4]);
        end
        ev = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nchecks++;
        if (spike !== 4'b0000) begin
            nerrors++;
            $display("FAIL post_rst_1: got %b want 0000", spike);
        end
        @(negedge clk);
        nchecks++;
        if (spike !== 4'b0000) begin
            nerrors++;
            $display("FAIL post_rst_2: got %b want 0000", spike);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ev    = '0;
        test_reset();
        test_pair_spike();
        test_single_then_repeat();
        test_decay();
        test_tie();
        test_neuron3();
        test_back_to_back();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule

// File: doc/odesa_complete_top.md
ODESA_COMPLETE_TOP -- requirements
Module: odesa_complete

Interface
REQ-001 SHALL have parameter p_width, default 9: bit width of each input time-surface trace.
REQ-002 SHALL have parameter p_thr_init, default 512: reset value of every neuron threshold, (p_width+1) bits.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_event  input  8 ([8:1])  input event lines, level-sampled each rising edge; a 1 is one event.
REQ-006 SHALL have port o_spike_out  output  4 ([4:1])  registered one-hot output spikes, one bit per neuron.

Function
REQ-007 SHALL keep one trace register per input n (1..8), each p_width bits; TMAX = 2^p_width-1 (511 at default).
REQ-008 At each edge, for each n: i_event[n]=1 sets trace[n] to TMAX; otherwise trace[n] is decremented by 1, saturating at 0.
REQ-009 SHALL register an evaluation flag ev_q = OR of i_event at each edge.
REQ-010 Neuron k (1..4) potential P[k] = trace[2k-1] + trace[2k], (p_width+1) bits, no overflow; this is the fixed weight map, with no other inputs contributing.
REQ-011 P[k] is computed from trace values present before the evaluating edge, i.e. values written at the edge that set ev_q.
REQ-012 At an edge with ev_q=1, neuron k is eligible if P[k] >= thr[k] and P[k] > 0; the winner is the eligible neuron with the largest P; ties go to the lowest index.
REQ-013 At that edge o_spike_out SHALL be loaded with the winner's one-hot code, or 0 if none is eligible; at every edge with ev_q=0 it is loaded with 0.
REQ-014 Resulting latency: event sampled at edge E gives a spike visible after edge E+1, held exactly one cycle; it is never more than one bit high.
REQ-015 Threshold adaptation at an evaluating edge with a winner w: thr[w] <= thr[w] + ((P[w] - thr[w]) >> 2); the other thresholds are unchanged.
REQ-016 Threshold adaptation at an evaluating edge with no winner: every thr[k] is decremented by 1, saturating at 0.
REQ-017 Thresholds are (p_width+1) bits, unsigned, and never wrap.
REQ-018 Events held high on consecutive cycles SHALL evaluate on every cycle (ev_q=1 each cycle); there is no event-rate limiting.
REQ-019 Simultaneous events on several lines are all captured in the same edge; a single evaluation follows.

Reset
REQ-020 While i_rst_n=0, asynchronously and independent of the clock:
- all traces = 0
- ev_q = 0
- o_spike_out = 4'b0000
- every thr[k] = p_thr_init
REQ-021 Reset asserted mid-operation discards any pending evaluation; no spike is produced from events sampled before reset release.

Verification
REQ-022 Reset for 100 ns, then i_event=0 for 1000 cycles -> o_spike_out stays 4'b0000, all thr=512.
REQ-023 One-cycle pulse on i_event[1] and i_event[2] together -> P[1]=1022 >= 512; o_spike_out=4'b0001 for exactly one cycle, one edge after the sampling edge; thr[1] becomes 639.
REQ-024 One-cycle pulse on i_event[1] only -> P[1]=511 < 512, no spike, all thr become 511; a second pulse on i_event[1] 10 cycles later -> P[1]=511 >= 511, so o_spike_out=4'b0001 and thr[1] stays 511.
REQ-025 Pulse on i_event[1] at edge E0 (no spike, thr=511), then a pulse on i_event[2] at edge E0+200 -> P[1]=311+511=822, so o_spike_out=4'b0001 after edge E0+201.
REQ-026 Simultaneous pulse on i_event[4:1] -> P[1]=P[2]=1022 (tie), so o_spike_out=4'b0001 only; thr[2] remains 512.
REQ-027 Drive i_event=8'hFF, then assert i_rst_n=0 mid-stream between edges -> o_spike_out=0 immediately, traces 0, thr=512, and no spike in the first cycle after release if i_event=0.
